// File: rtl/demux64_capture_pkg.sv
// demux64_capture shared package
// Holds the state enum, slot geometry and the last-slot constant.
package demux64_pkg;

    localparam int N_SLOTS = 64;
    localparam int SEL_W   = 6;

    localparam logic [SEL_W-1:0] LAST_SLOT = 6'd63;

    typedef enum logic {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

endpackage

// File: rtl/demux64_capture_if.sv
// demux64_capture bus interface
// Bundles the capture controls, serial input and frame handshake.
// master: the producer/consumer side; slave: the capture block.
interface demux64_capture_if;
    import demux64_pkg::*;

    logic               start;
    logic               cont;
    logic               din;
    logic               din_valid;
    logic [N_SLOTS-1:0] frame;
    logic               frame_valid;
    logic               frame_ready;
    logic [SEL_W-1:0]   slot;
    logic               busy;
    logic               overrun;

    modport master (
        output start, cont, din, din_valid, frame_ready,
        input  frame, frame_valid, slot, busy, overrun
    );

    modport slave (
        input  start, cont, din, din_valid, frame_ready,
        output frame, frame_valid, slot, busy, overrun
    );

endinterface

// File: rtl/demux64_capture_slot_decoder.sv
// slot_decoder_6to64
// One-hot write enables for the shadow register.
// Ports: slot_i (slot index), en_i (write this cycle), we_o (per-slot enable).
module slot_decoder_6to64
    import demux64_pkg::*;
(
    input  logic [SEL_W-1:0]   slot_i,
    input  logic               en_i,
    output logic [N_SLOTS-1:0] we_o
);

    always_comb begin
        we_o = '0;
        if (en_i) begin
            we_o[slot_i] = 1'b1;
        end
    end

endmodule

// File: rtl/demux64_capture.sv
// demux64_capture
// Serial-to-parallel capture: steers din into 64 slots and hands out
// completed frames on a valid/ready bus.
// Ports: clk, rst (async, active-high), bus (slave side of the capture bus).
module demux64_capture
    import demux64_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    demux64_capture_if.slave   bus
);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   slot_q, slot_d;
    logic [N_SLOTS-1:0] shadow_q, shadow_d;
    logic [N_SLOTS-1:0] frame_q, frame_d;
    logic               fv_q, fv_d;
    logic               ovr_q, ovr_d;

    logic               capturing;
    logic               beat;
    logic               complete;
    logic               load;
    logic               accept;
    logic [N_SLOTS-1:0] we;

    assign capturing = (state_q == CAPTURE);
    assign beat      = capturing && bus.din_valid;
    assign complete  = beat && (slot_q == LAST_SLOT);
    assign accept    = fv_q && bus.frame_ready;
    // A completing frame may replace one that is being accepted now.
    assign load      = complete && (!fv_q || bus.frame_ready);

    slot_decoder_6to64 u_dec (
        .slot_i (slot_q),
        .en_i   (beat),
        .we_o   (we)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            slot_q   <= '0;
            shadow_q <= '0;
            frame_q  <= '0;
            fv_q     <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
            fv_q     <= fv_d;
            ovr_q    <= ovr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (complete) begin
                    state_d = bus.cont ? CAPTURE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        slot_d   = slot_q;
        shadow_d = shadow_q;
        frame_d  = frame_q;
        fv_d     = fv_q;
        ovr_d    = ovr_q;

        if (!capturing && bus.start) begin
            slot_d   = '0;
            shadow_d = '0;
            ovr_d    = 1'b0;
        end

        if (beat) begin
            shadow_d = (shadow_q & ~we) | (we & {N_SLOTS{bus.din}});
            slot_d   = slot_q + SEL_W'(1);
        end

        if (complete) begin
            shadow_d = '0;
            if (!load) begin
                ovr_d = 1'b1;
            end
        end

        if (load) begin
            frame_d = {bus.din, shadow_q[N_SLOTS-2:0]};
            fv_d    = 1'b1;
        end else if (accept) begin
            fv_d    = 1'b0;
        end
    end

    // Outputs (all registered)
    always_comb begin
        bus.busy        = capturing;
        bus.slot        = slot_q;
        bus.frame       = frame_q;
        bus.frame_valid = fv_q;
        bus.overrun     = ovr_q;
    end

endmodule

// File: tb/tb_demux64_capture.sv
// tb_demux64_capture
// Table vectors, directed corner sequences and random stimulus vs a queue model.
module tb_demux64_capture;

    logic clk = 1'b0;
    logic rst;

    demux64_capture_if bus ();

    demux64_capture dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a frame is just the list of accepted bits.
    bit          m_busy;
    bit          m_q[$];
    logic [63:0] m_frame;
    bit          m_fv;
    bit          m_ovr;

    typedef struct {
        bit st, cn, d, dv, fr;
        int e_slot;
        bit e_busy, e_fv;
    } vec_t;

    vec_t tv[8];

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_busy  = 0;
        m_q.delete();
        m_frame = '0;
        m_fv    = 0;
        m_ovr   = 0;
    endtask

    task automatic m_step();
        bit acc, loaded;
        logic [63:0] f;
        acc    = m_fv && bus.frame_ready;
        loaded = 0;
        if (!m_busy) begin
            if (bus.start) begin
                m_busy = 1;
                m_q.delete();
                m_ovr = 0;
            end
        end else if (bus.din_valid) begin
            m_q.push_back(bus.din);
            if (m_q.size() == 64) begin
                for (int k = 0; k < 64; k++) f[k] = m_q[k];
                if (!m_fv || bus.frame_ready) begin
                    m_frame = f;
                    loaded  = 1;
                end else begin
                    m_ovr = 1;
                end
                m_q.delete();
                m_busy = bus.cont;
            end
        end
        if (loaded) m_fv = 1;
        else if (acc) m_fv = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) m_reset();
        else m_step();
        #1;
        chk("slot", 64'(bus.slot), 64'(m_q.size()));
        chk("busy", 64'(bus.busy), 64'(m_busy));
        chk("fv", 64'(bus.frame_valid), 64'(m_fv));
        chk("ovr", 64'(bus.overrun), 64'(m_ovr));
        chk("frame", bus.frame, m_frame);
    endtask

    task automatic idle_in();
        bus.start = 0;
        bus.din_valid = 0;
        bus.din = 0;
        bus.frame_ready = 0;
    endtask

    task automatic beat(bit d);
        bus.din_valid = 1;
        bus.din = d;
        cyc();
        bus.din_valid = 0;
    endtask

    task automatic do_start();
        bus.start = 1;
        cyc();
        bus.start = 0;
    endtask

    task automatic do_accept();
        bus.frame_ready = 1;
        cyc();
        bus.frame_ready = 0;
    endtask

    initial begin
        logic [5:0] k6;
        idle_in();
        bus.cont = 0;
        m_reset();
        rst = 1;
        #12;
        chk("rst_slot", 64'(bus.slot), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_fv", 64'(bus.frame_valid), 64'd0);
        chk("rst_frame", bus.frame, 64'd0);
        @(negedge clk);
        rst = 0;

        tv[0] = '{1, 0, 1, 1, 0, 0, 1, 0};
        tv[1] = '{0, 0, 1, 1, 0, 1, 1, 0};
        tv[2] = '{0, 0, 0, 0, 0, 1, 1, 0};
        tv[3] = '{0, 0, 0, 1, 0, 2, 1, 0};
        tv[4] = '{1, 0, 1, 1, 0, 3, 1, 0};
        tv[5] = '{0, 0, 0, 0, 1, 3, 1, 0};
        tv[6] = '{0, 0, 1, 1, 0, 4, 1, 0};
        tv[7] = '{0, 0, 0, 1, 0, 5, 1, 0};
        for (int i = 0; i < 8; i++) begin
            bus.start = tv[i].st;
            bus.cont = tv[i].cn;
            bus.din = tv[i].d;
            bus.din_valid = tv[i].dv;
            bus.frame_ready = tv[i].fr;
            cyc();
            chk($sformatf("tv%0d_slot", i), 64'(bus.slot), 64'(tv[i].e_slot));
            chk($sformatf("tv%0d_busy", i), 64'(bus.busy), 64'(tv[i].e_busy));
            chk($sformatf("tv%0d_fv", i), 64'(bus.frame_valid), 64'(tv[i].e_fv));
        end
        idle_in();

        // Reset mid-capture after 20 beats
        for (int i = 0; i < 15; i++) beat(1);
        chk("pre_rst_slot", 64'(bus.slot), 64'd20);
        rst = 1;
        #1;
        chk("arst_slot", 64'(bus.slot), 64'd0);
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_frame", bus.frame, 64'd0);
        bus.din_valid = 1;
        bus.din = 1;
        cyc();
        rst = 0;
        cyc();
        cyc();
        chk("post_rst_slot", 64'(bus.slot), 64'd0);
        chk("post_rst_busy", 64'(bus.busy), 64'd0);
        idle_in();

        // Single frame, din = slot[0]
        do_start();
        for (int k = 0; k < 64; k++) beat(k[0]);
        chk("single_frame", bus.frame, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("single_fv", 64'(bus.frame_valid), 64'd1);
        chk("single_busy", 64'(bus.busy), 64'd0);
        do_accept();
        chk("single_acc_fv", 64'(bus.frame_valid), 64'd0);

        // Gapped input, beats every third cycle
        do_start();
        for (int k = 0; k < 64; k++) begin
            beat(k == 5 || k == 63);
            cyc();
            cyc();
        end
        chk("gap_frame", bus.frame, 64'h8000_0000_0000_0020);
        do_accept();

        // Continuous overrun
        bus.cont = 1;
        do_start();
        for (int k = 0; k < 64; k++) beat(1);
        for (int k = 0; k < 64; k++) begin
            if (k == 63) bus.cont = 0;
            beat(0);
        end
        chk("ovr_frame", bus.frame, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ovr_flag", 64'(bus.overrun), 64'd1);
        do_start();
        chk("ovr_cleared", 64'(bus.overrun), 64'd0);

        // Accept and complete in the same cycle
        do_accept();
        bus.cont = 1;
        for (int k = 0; k < 64; k++) begin
            k6 = 6'(k);
            beat(k6[1]);
        end
        chk("simA_frame", bus.frame, 64'hCCCC_CCCC_CCCC_CCCC);
        bus.cont = 0;
        for (int k = 0; k < 64; k++) begin
            k6 = 6'(k);
            if (k == 63) bus.frame_ready = 1;
            beat(k6[2]);
            bus.frame_ready = 0;
        end
        chk("simB_frame", bus.frame, 64'hF0F0_F0F0_F0F0_F0F0);
        chk("simB_fv", 64'(bus.frame_valid), 64'd1);
        chk("simB_ovr", 64'(bus.overrun), 64'd0);
        do_accept();

        // start during capture is ignored
        do_start();
        for (int k = 0; k < 30; k++) beat(0);
        bus.start = 1;
        beat(1);
        bus.start = 0;
        chk("ign_start_slot", 64'(bus.slot), 64'd31);
        for (int k = 31; k < 64; k++) beat(0);
        chk("ign_frame", bus.frame, 64'h0000_0000_4000_0000);
        do_accept();

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            bus.start = ($urandom_range(15) == 0);
            if ($urandom_range(31) == 0) bus.cont = $urandom_range(1);
            bus.din = $urandom_range(1);
            bus.din_valid = ($urandom_range(3) != 0);
            bus.frame_ready = ($urandom_range(3) == 0);
            cyc();
        end
        idle_in();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
